uart_inst_loader: RTL and testbench

- Boot-time program loader that sits directly upstream of the core's instruction memory.
- Receives a length-prefixed program image over a UART RX line, assembles 32-bit big-endian words and writes them into the instruction memory through a single write port.
- Raises DONE when the image is complete; DONE gates the core's INIT→RUN transition in place of a compiled-in program image.

---
 rtl/uart_inst_loader_if.sv | 24 ++
 rtl/uart_inst_loader.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_inst_loader.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_inst_loader_if.sv
// Boot-loader bus: serial input plus the instruction-memory write port and status flags.
// master = loader side, slave = memory / core / LED side.
interface uart_inst_loader_if #(
    parameter int ADDR_W = 8
);
    logic              UART_RX;
    logic              INST_WE;
    logic [ADDR_W-1:0] INST_WADDR;
    logic [31:0]       INST_WDATA;
    logic [ADDR_W:0]   WORDS_LOADED;
    logic              BUSY;
    logic              DONE;
    logic              ERR;

    modport master (
        input  UART_RX,
        output INST_WE, INST_WADDR, INST_WDATA, WORDS_LOADED, BUSY, DONE, ERR
    );

    modport slave (
        output UART_RX,
        input  INST_WE, INST_WADDR, INST_WDATA, WORDS_LOADED, BUSY, DONE, ERR
    );
endinterface

// File: rtl/uart_inst_loader.sv
// UART program loader: 8N1 receiver feeding a length-prefixed big-endian word assembler.
// Define UART_INST_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_inst_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 8,
    parameter int MAX_WORDS    = 200
) (
    input  logic               CLK,
    input  logic               RST,
    uart_inst_loader_if.master bus
);

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W:0]  WORD_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {LD_HDR, LD_DATA, LD_CSUM, LD_DONE, LD_ERROR} ld_state_t;

    logic             rx_meta_reg;
    logic             rx_sync_reg;
    logic             rx_prev_reg;
    rx_state_t        rx_state_reg;
    logic [CNT_W-1:0] rx_cnt_reg;
    logic [2:0]       rx_bit_reg;
    logic [7:0]       rx_shift_reg;
    logic [7:0]       rx_byte_reg;
    logic             byte_valid_reg;
    logic             frame_err_reg;
    logic             rx_started_reg;

    ld_state_t        ld_state_reg;
    logic [1:0]       byte_cnt_reg;
    logic [23:0]      shift_reg;
    logic [ADDR_W:0]  n_reg;
    logic             inst_we_reg;
    logic [ADDR_W-1:0] inst_waddr_reg;
    logic [31:0]      inst_wdata_reg;
    logic [ADDR_W:0]  words_loaded_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             err_reg;
`ifdef UART_INST_LOADER_CHECKSUM_EN
    logic [7:0]       csum_reg;
`endif

    // Word formed by the three previous bytes plus the byte arriving now.
    logic [31:0] word_next;
    assign word_next = {shift_reg, rx_byte_reg};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
        end else begin
            rx_meta_reg <= bus.UART_RX;
            rx_sync_reg <= rx_meta_reg;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_state_reg   <= RX_IDLE;
            rx_prev_reg    <= 1'b1;
            rx_cnt_reg     <= '0;
            rx_bit_reg     <= '0;
            rx_shift_reg   <= '0;
            rx_byte_reg    <= '0;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            rx_started_reg <= 1'b0;
        end else begin
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            rx_started_reg <= 1'b0;
            rx_prev_reg    <= rx_sync_reg;
            case (rx_state_reg)
                RX_IDLE: begin
                    rx_cnt_reg <= '0;
                    if (rx_prev_reg && !rx_sync_reg)
                        rx_state_reg <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt_reg == HALF_LAST) begin
                        rx_cnt_reg <= '0;
                        // A line already back high at mid-bit was only a glitch.
                        if (rx_sync_reg) begin
                            rx_state_reg <= RX_IDLE;
                        end else begin
                            rx_state_reg   <= RX_DATA;
                            rx_bit_reg     <= '0;
                            rx_started_reg <= 1'b1;
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_reg == BIT_LAST) begin
                        rx_cnt_reg   <= '0;
                        rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
                        if (rx_bit_reg == 3'd7)
                            rx_state_reg <= RX_STOP;
                        else
                            rx_bit_reg <= rx_bit_reg + 3'd1;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_reg == BIT_LAST) begin
                        rx_cnt_reg   <= '0;
                        rx_state_reg <= RX_IDLE;
                        if (rx_sync_reg) begin
                            byte_valid_reg <= 1'b1;
                            rx_byte_reg    <= rx_shift_reg;
                        end else begin
                            frame_err_reg <= 1'b1;
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
                    end
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ld_state_reg     <= LD_HDR;
            byte_cnt_reg     <= '0;
            shift_reg        <= '0;
            n_reg            <= '0;
            inst_we_reg      <= 1'b0;
            inst_waddr_reg   <= '0;
            inst_wdata_reg   <= '0;
            words_loaded_reg <= '0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            err_reg          <= 1'b0;
`ifdef UART_INST_LOADER_CHECKSUM_EN
            csum_reg         <= '0;
`endif
        end else begin
            inst_we_reg <= 1'b0;
            if (frame_err_reg && ld_state_reg != LD_DONE && ld_state_reg != LD_ERROR) begin
                ld_state_reg <= LD_ERROR;
                err_reg      <= 1'b1;
                busy_reg     <= 1'b0;
            end else begin
                case (ld_state_reg)
                    LD_HDR: begin
                        if (rx_started_reg)
                            busy_reg <= 1'b1;
                        if (byte_valid_reg) begin
                            shift_reg    <= word_next[23:0];
                            byte_cnt_reg <= byte_cnt_reg + 2'd1;
                            if (byte_cnt_reg == 2'd3) begin
                                if (word_next == 32'd0) begin
`ifdef UART_INST_LOADER_CHECKSUM_EN
                                    ld_state_reg <= LD_CSUM;
`else
                                    ld_state_reg <= LD_DONE;
                                    done_reg     <= 1'b1;
                                    busy_reg     <= 1'b0;
`endif
                                end else if (word_next > 32'(MAX_WORDS)) begin
                                    ld_state_reg <= LD_ERROR;
                                    err_reg      <= 1'b1;
                                    busy_reg     <= 1'b0;
                                end else begin
                                    ld_state_reg <= LD_DATA;
                                    n_reg        <= word_next[ADDR_W:0];
                                end
                            end
                        end
                    end
                    LD_DATA: begin
                        if (byte_valid_reg) begin
                            shift_reg    <= word_next[23:0];
                            byte_cnt_reg <= byte_cnt_reg + 2'd1;
`ifdef UART_INST_LOADER_CHECKSUM_EN
                            csum_reg     <= csum_reg ^ rx_byte_reg;
`endif
                            if (byte_cnt_reg == 2'd3) begin
                                inst_we_reg      <= 1'b1;
                                inst_waddr_reg   <= words_loaded_reg[ADDR_W-1:0];
                                inst_wdata_reg   <= word_next;
                                words_loaded_reg <= words_loaded_reg + WORD_ONE;
                            end
                        end else if (inst_we_reg && words_loaded_reg == n_reg) begin
                            // Last word is on the port this cycle; finish on the next.
`ifdef UART_INST_LOADER_CHECKSUM_EN
                            ld_state_reg <= LD_CSUM;
`else
                            ld_state_reg <= LD_DONE;
                            done_reg     <= 1'b1;
                            busy_reg     <= 1'b0;
`endif
                        end
                    end
`ifdef UART_INST_LOADER_CHECKSUM_EN
                    LD_CSUM: begin
                        if (byte_valid_reg) begin
                            busy_reg <= 1'b0;
                            if (rx_byte_reg == csum_reg) begin
                                ld_state_reg <= LD_DONE;
                                done_reg     <= 1'b1;
                            end else begin
                                ld_state_reg <= LD_ERROR;
                                err_reg      <= 1'b1;
                            end
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign bus.INST_WE      = inst_we_reg;
    assign bus.INST_WADDR   = inst_waddr_reg;
    assign bus.INST_WDATA   = inst_wdata_reg;
    assign bus.WORDS_LOADED = words_loaded_reg;
    assign bus.BUSY         = busy_reg;
    assign bus.DONE         = done_reg;
    assign bus.ERR          = err_reg;

endmodule

// File: tb/tb_uart_inst_loader.sv
// Scoreboard bench for uart_inst_loader: serial images in, expected writes queued and
// popped as INST_WE appears. Honours UART_INST_LOADER_CHECKSUM_EN.
module tb_uart_inst_loader;

    localparam int CPB = 16;
    localparam int AW  = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    uart_inst_loader_if #(.ADDR_W(AW)) bus ();

    uart_inst_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW),
        .MAX_WORDS   (200)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_we_cyc = -1;
    int         done_cyc = -1;
    int         exp_addr = 0;
    logic [7:0] csum_acc = 8'h00;

    always @(posedge CLK) cyc++;

    // Write monitor: every strobe must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (!RST && bus.INST_WE === 1'b1) begin
            last_we_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %08h, required no write", bus.INST_WADDR, bus.INST_WDATA);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.INST_WADDR !== mon_e.addr || bus.INST_WDATA !== mon_e.data) begin
                    errors++;
                    $display("FAIL write: got addr %0d data %08h, required addr %0d data %08h", bus.INST_WADDR, bus.INST_WDATA, mon_e.addr, mon_e.data);
                end else begin
                    $display("write addr %0d data %08h ok", bus.INST_WADDR, bus.INST_WDATA);
                end
            end
        end
        if (!RST && bus.DONE === 1'b1 && done_cyc < 0)
            done_cyc = cyc;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bus.UART_RX = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            bus.UART_RX = b[i];
            repeat (CPB) @(negedge CLK);
        end
        bus.UART_RX = stop;
        repeat (CPB) @(negedge CLK);
        bus.UART_RX = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic send_header(input logic [31:0] n);
        csum_acc = 8'h00;
        for (int i = 0; i < 4; i++) send_byte(n[31-8*i -: 8], 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit push);
        logic [7:0] b;
        if (push) begin
            exp_q.push_back({AW'(exp_addr), w});
            exp_addr++;
        end
        for (int i = 0; i < 4; i++) begin
            b = w[31-8*i -: 8];
            csum_acc = csum_acc ^ b;
            send_byte(b, 1'b1);
        end
    endtask

    task automatic send_trailer();
`ifdef UART_INST_LOADER_CHECKSUM_EN
        send_byte(csum_acc, 1'b1);
`endif
    endtask

    task automatic wait_status(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (bus.DONE === 1'b1 || bus.ERR === 1'b1) break;
            @(negedge CLK);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        bus.UART_RX = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        exp_q.delete();
        exp_addr = 0;
        done_cyc = -1;
        last_we_cyc = -1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset();
        bus.UART_RX = 1'b1;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        checks++; if (bus.INST_WE !== 1'b0) begin errors++; $display("FAIL reset_we: got %b required 0", bus.INST_WE); end
        checks++; if (bus.INST_WADDR !== '0) begin errors++; $display("FAIL reset_waddr: got %0d required 0", bus.INST_WADDR); end
        checks++; if (bus.INST_WDATA !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %08h required 0", bus.INST_WDATA); end
        checks++; if (bus.WORDS_LOADED !== '0) begin errors++; $display("FAIL reset_words: got %0d required 0", bus.WORDS_LOADED); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus.BUSY); end
        checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", bus.DONE); end
        checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", bus.ERR); end
        $display("test_reset done");
        RST = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_image();
        do_reset();
        send_header(32'd2);
        checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL image_busy: got %b required 1", bus.BUSY); end
        send_word(32'h2001_0005, 1'b1);
        send_word(32'h0800_0000, 1'b1);
`ifdef UART_INST_LOADER_CHECKSUM_EN
        checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL image_done_early: got %b required 0", bus.DONE); end
        send_trailer();
`endif
        wait_status(200);
        checks++; if (bus.DONE !== 1'b1) begin errors++; $display("FAIL image_done: got %b required 1", bus.DONE); end
        checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL image_err: got %b required 0", bus.ERR); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL image_busy_end: got %b required 0", bus.BUSY); end
        checks++; if (bus.WORDS_LOADED !== 9'd2) begin errors++; $display("FAIL image_words: got %0d required 2", bus.WORDS_LOADED); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL image_pending: got %0d writes outstanding required 0", exp_q.size()); end
`ifndef UART_INST_LOADER_CHECKSUM_EN
        checks++; if (done_cyc != last_we_cyc + 1) begin errors++; $display("FAIL image_done_latency: got cycle %0d required %0d", done_cyc, last_we_cyc + 1); end
`endif
        $display("test_image done");
    endtask

    task automatic test_oversize();
        do_reset();
        send_header(32'h0000_00C9);
        repeat (30) @(negedge CLK);
        checks++; if (bus.ERR !== 1'b1) begin errors++; $display("FAIL oversize_err: got %b required 1", bus.ERR); end
        checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL oversize_done: got %b required 0", bus.DONE); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL oversize_busy: got %b required 0", bus.BUSY); end
        send_word(32'h1234_5678, 1'b0);
        repeat (10) @(negedge CLK);
        checks++; if (bus.WORDS_LOADED !== '0) begin errors++; $display("FAIL oversize_words: got %0d required 0", bus.WORDS_LOADED); end
        $display("test_oversize done");
    endtask

    task automatic test_glitch();
        do_reset();
        send_header(32'd2);
        send_word(32'hA5A5_0001, 1'b1);
        bus.UART_RX = 1'b0;
        repeat (5) @(negedge CLK);
        bus.UART_RX = 1'b1;
        repeat (40) @(negedge CLK);
        checks++; if (bus.WORDS_LOADED !== 9'd1) begin errors++; $display("FAIL glitch_words: got %0d required 1", bus.WORDS_LOADED); end
        checks++; if (bus.BUSY !== 1'b1 || bus.ERR !== 1'b0 || bus.DONE !== 1'b0) begin errors++; $display("FAIL glitch_status: got busy %b err %b done %b required 1 0 0", bus.BUSY, bus.ERR, bus.DONE); end
        send_word(32'h5A5A_FFFE, 1'b1);
        send_trailer();
        wait_status(200);
        checks++; if (bus.DONE !== 1'b1) begin errors++; $display("FAIL glitch_done: got %b required 1", bus.DONE); end
        checks++; if (bus.WORDS_LOADED !== 9'd2) begin errors++; $display("FAIL glitch_words_end: got %0d required 2", bus.WORDS_LOADED); end
        $display("test_glitch done");
    endtask

    task automatic test_framing();
        do_reset();
        send_header(32'd2);
        send_word(32'hDEAD_0001, 1'b1);
        send_byte(8'h55, 1'b0);
        repeat (5) @(negedge CLK);
        checks++; if (bus.ERR !== 1'b1) begin errors++; $display("FAIL framing_err: got %b required 1", bus.ERR); end
        checks++; if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) begin errors++; $display("FAIL framing_status: got done %b busy %b required 0 0", bus.DONE, bus.BUSY); end
        send_word(32'h0102_0304, 1'b0);
        repeat (10) @(negedge CLK);
        checks++; if (bus.WORDS_LOADED !== 9'd1) begin errors++; $display("FAIL framing_words: got %0d required 1", bus.WORDS_LOADED); end
        $display("test_framing done");
    endtask

    task automatic test_reset_midword();
        logic [7:0] b;
        do_reset();
        send_header(32'd2);
        send_word(32'h1122_3344, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        b = 8'hCC;
        bus.UART_RX = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            bus.UART_RX = b[i];
            repeat (CPB) @(negedge CLK);
        end
        RST = 1'b1;
        bus.UART_RX = 1'b1;
        #1;
        checks++; if (bus.INST_WE !== 1'b0 || bus.WORDS_LOADED !== '0 || bus.INST_WADDR !== '0 || bus.INST_WDATA !== 32'h0) begin errors++; $display("FAIL midreset_port: got we %b words %0d addr %0d data %08h required all 0", bus.INST_WE, bus.WORDS_LOADED, bus.INST_WADDR, bus.INST_WDATA); end
        checks++; if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.ERR !== 1'b0) begin errors++; $display("FAIL midreset_status: got busy %b done %b err %b required 0 0 0", bus.BUSY, bus.DONE, bus.ERR); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL midreset_pending: got %0d writes outstanding required 0", exp_q.size()); end
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        exp_q.delete();
        exp_addr = 0;
        done_cyc = -1;
        repeat (2) @(negedge CLK);
        send_header(32'd2);
        send_word(32'hCAFE_F00D, 1'b1);
        send_word(32'h0BAD_BEEF, 1'b1);
        send_trailer();
        wait_status(200);
        checks++; if (bus.DONE !== 1'b1 || bus.ERR !== 1'b0) begin errors++; $display("FAIL midreset_reload: got done %b err %b required 1 0", bus.DONE, bus.ERR); end
        checks++; if (bus.WORDS_LOADED !== 9'd2) begin errors++; $display("FAIL midreset_words: got %0d required 2", bus.WORDS_LOADED); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL midreset_reload_pending: got %0d outstanding required 0", exp_q.size()); end
        $display("test_reset_midword done");
    endtask

    task automatic test_zero();
        do_reset();
        send_header(32'd0);
`ifdef UART_INST_LOADER_CHECKSUM_EN
        send_byte(8'h01, 1'b1);
        wait_status(100);
        checks++; if (bus.ERR !== 1'b1) begin errors++; $display("FAIL zero_err: got %b required 1", bus.ERR); end
        checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL zero_done: got %b required 0", bus.DONE); end
`else
        wait_status(100);
        checks++; if (bus.DONE !== 1'b1) begin errors++; $display("FAIL zero_done: got %b required 1", bus.DONE); end
        checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL zero_err: got %b required 0", bus.ERR); end
`endif
        checks++; if (bus.WORDS_LOADED !== '0 || bus.BUSY !== 1'b0) begin errors++; $display("FAIL zero_words: got words %0d busy %b required 0 0", bus.WORDS_LOADED, bus.BUSY); end
        $display("test_zero done");
    endtask

    initial begin
        bus.UART_RX = 1'b1;
        test_reset();
        test_image();
        test_oversize();
        test_glitch();
        test_framing();
        test_reset_midword();
        test_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
